// File: rtl/nvdla_package.sv
// Shared types and constants for the NVDLA TCDM request arbiter.
// The requester ID constants double as rr_ptr values and as ID FIFO payloads.
package nvdla_package;

  localparam logic ID_CSB = 1'b0;
  localparam logic ID_DBB = 1'b1;

  // Fixed export width so the flags struct does not depend on N_OUTST.
  localparam int FLAGS_CNT_W = 8;

  typedef struct packed {
    logic                   busy;
    logic [FLAGS_CNT_W-1:0] outst_cnt;
    logic                   rr_ptr;
    logic                   err;
  } flags_tcdm_arb_t;

endpackage

// File: rtl/nvdla_id_fifo.sv
// Small FIFO of 1-bit requester IDs for outstanding TCDM transactions.
// Pushes while full and pops while empty are ignored, so the count never wraps.
module nvdla_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     data_i,
  output logic                     data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CNT_MAX);
  assign empty_o = (r_count == {CNT_W{1'b0}});
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  // Storage, pointers and occupancy; clear_i flushes like a reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_mem    <= {DEPTH{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nvdla_tcdm_arbiter.sv
// Two-requester (CSB, DBB) round-robin arbiter onto one TCDM port, with an ID
// FIFO that routes zero-latency responses back to the requester that issued them.
module nvdla_tcdm_arbiter
  import nvdla_package::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_OUTST    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    csb_req_i,
  input  logic                    dbb_req_i,
  output logic                    csb_gnt_o,
  output logic                    dbb_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   csb_add_i,
  input  logic [ADDR_WIDTH-1:0]   dbb_add_i,
  input  logic                    csb_wen_i,
  input  logic                    dbb_wen_i,
  input  logic [DATA_WIDTH/8-1:0] csb_be_i,
  input  logic [DATA_WIDTH/8-1:0] dbb_be_i,
  input  logic [DATA_WIDTH-1:0]   csb_data_i,
  input  logic [DATA_WIDTH-1:0]   dbb_data_i,
  output logic                    csb_r_valid_o,
  output logic                    dbb_r_valid_o,
  output logic [DATA_WIDTH-1:0]   csb_r_data_o,
  output logic [DATA_WIDTH-1:0]   dbb_r_data_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o,
  input  logic                    tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
  output flags_tcdm_arb_t         flags_o
);

  localparam int CNT_W = $clog2(N_OUTST) + 1;

  logic             r_rr_ptr;
  logic             r_err;
  logic             w_sel;
  logic             w_hs;
  logic             w_pop;
  logic             w_stray;
  logic             w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;

  // Winner selection: a lone requester wins, a tie goes to rr_ptr.
  always_comb begin
    w_sel = ID_CSB;
    if (csb_req_i && dbb_req_i) begin
      w_sel = r_rr_ptr;
    end else if (dbb_req_i) begin
      w_sel = ID_DBB;
    end else begin
      w_sel = ID_CSB;
    end
  end

  assign tcdm_req_o  = (csb_req_i | dbb_req_i) & ~w_full & ~clear_i & ~rst_i;
  assign w_hs        = tcdm_req_o & tcdm_gnt_i;
  assign csb_gnt_o   = w_hs & (w_sel == ID_CSB);
  assign dbb_gnt_o   = w_hs & (w_sel == ID_DBB);
  assign tcdm_add_o  = (w_sel == ID_DBB) ? dbb_add_i  : csb_add_i;
  assign tcdm_wen_o  = (w_sel == ID_DBB) ? dbb_wen_i  : csb_wen_i;
  assign tcdm_be_o   = (w_sel == ID_DBB) ? dbb_be_i   : csb_be_i;
  assign tcdm_data_o = (w_sel == ID_DBB) ? dbb_data_i : csb_data_i;

  // Responses during reset or flush are dropped silently; otherwise an empty FIFO is an error.
  assign w_pop         = tcdm_r_valid_i & ~w_empty & ~clear_i & ~rst_i;
  assign w_stray       = tcdm_r_valid_i &  w_empty & ~clear_i & ~rst_i;
  assign csb_r_valid_o = w_pop & (w_head == ID_CSB);
  assign dbb_r_valid_o = w_pop & (w_head == ID_DBB);
  assign csb_r_data_o  = tcdm_r_data_i;
  assign dbb_r_data_o  = tcdm_r_data_i;

  nvdla_id_fifo #(
    .DEPTH (N_OUTST)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (w_hs),
    .pop_i   (w_pop),
    .data_i  (w_sel),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Round-robin pointer moves to the loser of every accepted handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_rr_ptr <= ID_CSB;
    end else if (w_hs) begin
      r_rr_ptr <= ~w_sel;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // Sticky error for responses that have no outstanding transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_err <= 1'b0;
    end else if (w_stray) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign flags_o.busy      = (w_count != {CNT_W{1'b0}}) | csb_req_i | dbb_req_i;
  assign flags_o.outst_cnt = FLAGS_CNT_W'(w_count);
  assign flags_o.rr_ptr    = r_rr_ptr;
  assign flags_o.err       = r_err;

endmodule

// File: doc/nvdla_tcdm_arbiter.md
NVDLA_TCDM_ARBITER -- requirements
Module: nvdla_tcdm_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, TCDM address width.
REQ-002 Parameter DATA_WIDTH, default 32, TCDM data width; byte-enable width is DATA_WIDTH/8.
REQ-003 Parameter N_OUTST, default 4, maximum outstanding transactions (power of two, >=2).
REQ-004 Ports, one per line:
- clk_i  in  1  single clock.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  synchronous flush.
- csb_req_i/dbb_req_i  in  1  requester 0 (CSB) / 1 (DBB) request.
- csb_gnt_o/dbb_gnt_o  out  1  grant.
- csb_add_i/dbb_add_i  in  ADDR_WIDTH  address.
- csb_wen_i/dbb_wen_i  in  1  1=read, 0=write.
- csb_be_i/dbb_be_i  in  DATA_WIDTH/8  byte enable.
- csb_data_i/dbb_data_i  in  DATA_WIDTH  write data.
- csb_r_valid_o/dbb_r_valid_o  out  1  response valid.
- csb_r_data_o/dbb_r_data_o  out  DATA_WIDTH  response data.
- tcdm_req_o  out  1  upstream request.
- tcdm_gnt_i  in  1  upstream grant.
- tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o  out  as above  muxed request fields.
- tcdm_r_valid_i  in  1  upstream response valid.
- tcdm_r_data_i  in  DATA_WIDTH  upstream response data.
- flags_o  out  struct  busy, outst_cnt, rr_ptr, err.

Function
REQ-005 Request path combinational: tcdm_req_o = (csb_req_i|dbb_req_i) & ~full & ~clear_i; fields muxed from the selected requester.
REQ-006 Selection: single requester wins; both requesting -> requester indicated by rr_ptr wins.
REQ-007 Grant: selected requester's gnt_o = tcdm_gnt_i & tcdm_req_o; other gnt_o = 0, same cycle.
REQ-008 rr_ptr updates on each accepted handshake (tcdm_req_o & tcdm_gnt_i) to the loser index; unchanged otherwise; reset value 0 (CSB priority).
REQ-009 Each handshake (read or write) pushes the winner ID into an ID FIFO of depth N_OUTST.
REQ-010 tcdm_r_valid_i pops the FIFO head and routes r_valid/r_data to that ID in the same cycle (zero latency); the other r_valid_o = 0.
REQ-011 r_data_o of both requesters is driven by tcdm_r_data_i unconditionally; only r_valid_o is gated.
REQ-012 full = (outst_cnt == N_OUTST); a push while full is impossible because tcdm_req_o is masked; a pop while full frees the slot for the next cycle only.
REQ-013 Simultaneous push and pop leave outst_cnt unchanged; FIFO order is preserved.
REQ-014 tcdm_r_valid_i while FIFO empty: no r_valid_o, no pop, sticky err set.
REQ-015 outst_cnt width is clog2(N_OUTST)+1, and it never wraps.
REQ-016 busy = (outst_cnt != 0) | csb_req_i | dbb_req_i.
REQ-017 clear_i: same cycle, masks tcdm_req_o and all grants; next cycle, FIFO empty, outst_cnt=0, rr_ptr=0, err=0; responses in the clear cycle are dropped without setting err.

Reset
REQ-018 rst_i sampled on clk_i edge; while high, FIFO pointers, outst_cnt, rr_ptr and err are 0, and tcdm_req_o, all gnt_o and all r_valid_o are 0.
REQ-019 Reset mid-transaction discards outstanding IDs; later responses set err.

Structure
REQ-020 flags_tcdm_arb_t and the requester ID constants (ID_CSB=0, ID_DBB=1) belong in nvdla_package.
REQ-021 The ID FIFO is a sub-module nvdla_id_fifo (1-bit data, depth N_OUTST, push/pop/full/empty/count).
REQ-022 No other state; total RTL 150-250 lines.

Verification
REQ-023 Both requesters hold req with tcdm_gnt_i=1 for 4 cycles -> grants alternate CSB, DBB, CSB, DBB, and the FIFO holds 0,1,0,1.
REQ-024 Four reads granted and tcdm_r_valid_i held low (N_OUTST=4) -> outst_cnt=4, tcdm_req_o=0 while requests persist; one r_valid -> issue resumes the next cycle.
REQ-025 Issue order CSB, DBB, then return responses 0xA5, 0x5A -> csb_r_valid_o with 0xA5 first, dbb_r_valid_o with 0x5A second.
REQ-026 Push and pop in the same cycle at outst_cnt=2 -> outst_cnt stays 2 and the routed ID is the older entry.
REQ-027 tcdm_r_valid_i with an empty FIFO -> flags_o.err=1 and no r_valid_o; clear_i pulse -> err=0.
REQ-028 rst_i asserted with 3 outstanding -> the cycle after, outst_cnt=0 and rr_ptr=0; a stray response sets err.
